// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch controller.
// Holds the FSM state encoding and the default address/instruction widths
// and reset PC. The HALT state only exists when FETCH_CTRL_MISALIGN_TRAP_EN
// is defined.
package fetch_pkg;

  localparam int          ADDR_WIDTH_DEF  = 32;
  localparam int          INSTR_WIDTH_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;

  // Instructions are 4 bytes, so the sequential PC step is a constant 4.
  localparam int          PC_STEP = 4;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch controller.
// Issues one imem request at a time, registers the returned instruction into
// a one-entry output slot towards decode, and handles branch/jump redirects,
// discarding responses that belong to a PC abandoned by a redirect.
// Optional feature macro: FETCH_CTRL_MISALIGN_TRAP_EN -- adds misalign_valid /
// misalign_pc outputs and a HALT state entered on a redirect to a
// non-word-aligned target. Without it the low two target bits are forced to 0.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int                    INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  ,
  output logic                   misalign_valid,
  output logic [ADDR_WIDTH-1:0]  misalign_pc
`endif
);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic                    req_fire;
  logic                    out_fire;
  logic                    slot_free;
  logic [ADDR_WIDTH-1:0]   redir_target;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  // A request may still be in flight while HALTed; remembering it lets an
  // aligned redirect route through DRAIN so the stale response is dropped.
  logic                    pending;
  logic                    pending_next;
  logic                    redir_bad;
`else
  logic                    unused_redirect_low;
`endif

  // Sequential PC step; wraps naturally modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] p);
    return p + ADDR_WIDTH'(PC_STEP);
  endfunction

  // The output slot can take a new instruction if it is empty or being drained
  // this very cycle, so a request is only offered when its result has a home.
  assign slot_free      = !out_valid || out_ready;
  assign imem_req_valid = (state == ST_REQ) && slot_free;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign out_fire       = out_valid && out_ready;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  assign redir_target = redirect_pc;
  assign redir_bad    = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_target        = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc[1:0];
`endif

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  // Whether an imem request will still be outstanding after this edge.
  always_comb begin
    pending_next = 1'b0;
    case (state)
      ST_REQ:   pending_next = req_fire;
      ST_WAIT,
      ST_DRAIN: pending_next = !imem_rsp_valid;
      ST_HALT:  pending_next = pending && !imem_rsp_valid;
      default:  pending_next = 1'b0;
    endcase
  end
`endif

  // Fetch FSM, PC and output slot; a redirect overrides every other event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_REQ;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      misalign_valid <= 1'b0;
      misalign_pc    <= '0;
      pending        <= 1'b0;
`endif
    end else begin
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      misalign_valid <= 1'b0;
`endif
      if (redirect_valid) begin
        pc        <= redir_target;
        out_valid <= 1'b0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        pending   <= pending_next;
        if (redir_bad) begin
          misalign_valid <= 1'b1;
          misalign_pc    <= redirect_pc;
          state          <= ST_HALT;
        end else
`endif
        case (state)
          // A request accepted on the redirect edge returns stale data.
          ST_REQ:   state <= req_fire ? ST_DRAIN : ST_REQ;
          // A response arriving now is simply dropped; otherwise wait it out.
          ST_WAIT:  state <= imem_rsp_valid ? ST_REQ : ST_DRAIN;
          ST_DRAIN: state <= imem_rsp_valid ? ST_REQ : ST_DRAIN;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
          ST_HALT:  state <= (pending && !imem_rsp_valid) ? ST_DRAIN : ST_REQ;
`endif
          default:  state <= ST_REQ;
        endcase
      end else begin
        if (out_fire) begin
          out_valid <= 1'b0;
        end
        case (state)
          ST_REQ: begin
            if (req_fire) begin
              state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (imem_rsp_valid) begin
              out_valid <= 1'b1;
              out_instr <= imem_rsp_data;
              out_pc    <= pc;
              pc        <= pc_inc(pc);
              state     <= ST_REQ;
            end
          end
          ST_DRAIN: begin
            if (imem_rsp_valid) begin
              state <= ST_REQ;
            end
          end
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
          ST_HALT: begin
            if (imem_rsp_valid) begin
              pending <= 1'b0;
            end
          end
`endif
          default: state <= ST_REQ;
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PC/address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  ADDR_WIDTH  redirect target.
REQ-008 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-009 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-010 SHALL have port imem_req_addr  output  ADDR_WIDTH  byte address of request.
REQ-011 SHALL have port imem_rsp_valid  input  1  response data valid.
REQ-012 SHALL have port imem_rsp_data  input  INSTR_WIDTH  returned instruction.
REQ-013 SHALL have port out_valid  output  1  instruction available to decode.
REQ-014 SHALL have port out_ready  input  1  decode accepts instruction.
REQ-015 SHALL have port out_instr  output  INSTR_WIDTH  registered instruction.
REQ-016 SHALL have port out_pc  output  ADDR_WIDTH  PC of out_instr.

Function
REQ-017 SHALL keep at most one imem request outstanding; request handshake = imem_req_valid & imem_req_ready.
REQ-018 SHALL implement FSM states REQ, WAIT, DRAIN.
REQ-019 REQ: imem_req_valid=1 iff output slot free (out_valid=0 or out_ready=1), imem_req_addr=pc; on handshake -> WAIT.
REQ-020 WAIT: imem_req_valid=0; on imem_rsp_valid capture data into out_instr, pc into out_pc, set out_valid, pc<=pc+4, -> REQ.
REQ-021 out_valid SHALL clear on out_valid&out_ready unless a response is captured the same cycle; out_instr/out_pc SHALL hold stable while out_valid&!out_ready.
REQ-022 redirect_valid SHALL have priority over all other events: pc<=redirect_pc, out_valid<=0 same edge.
REQ-023 Redirect in REQ with no same-cycle handshake -> stay REQ; with same-cycle handshake -> DRAIN.
REQ-024 Redirect in WAIT with same-cycle imem_rsp_valid -> response discarded, -> REQ; without -> DRAIN.
REQ-025 DRAIN: imem_req_valid=0; on imem_rsp_valid discard data, -> REQ; further redirect in DRAIN updates pc, stays DRAIN.
REQ-026 pc+4 SHALL wrap modulo 2^ADDR_WIDTH without flag.
REQ-027 Minimum latency: request issue to out_valid = memory latency + 1 cycle (response registered).

Reset
REQ-028 Reset SHALL force state=REQ, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0 asynchronously; any in-flight response after reset release while in REQ SHALL be ignored (memory side resets together).

Configuration
REQ-029 With FETCH_CTRL_MISALIGN_TRAP_EN defined: ports misalign_valid (output 1) and misalign_pc (output ADDR_WIDTH) SHALL exist; redirect with redirect_pc[1:0]!=0 pulses misalign_valid one cycle, registers misalign_pc, and FSM enters HALT (no requests) until next aligned redirect.
REQ-030 Without FETCH_CTRL_MISALIGN_TRAP_EN: no misalign ports, no HALT state; redirect_pc[1:0] SHALL be forced to 00.

Structure
REQ-031 Package fetch_pkg SHALL hold the FSM state enum, ADDR_WIDTH/INSTR_WIDTH defaults and RESET_PC default.
REQ-032 Single module; no sub-module required.

Verification
REQ-033 Reset release, imem_req_ready=1, 1-cycle memory -> first request addr 0x0, out_valid with out_pc 0x0, then 0x4, 0x8 sequence.
REQ-034 out_ready=0 held 5 cycles with out_valid=1 -> no new request, out_instr/out_pc stable; out_ready=1 -> next request same cycle.
REQ-035 Redirect to 0x100 while in WAIT (3-cycle memory) -> response for old PC discarded, next request addr 0x100, out_pc 0x100.
REQ-036 Redirect coinciding with imem_rsp_valid -> no out_valid that cycle, next request at redirect_pc.
REQ-037 PC=0xFFFFFFFC fetch -> next request addr 0x00000000.
REQ-038 Macro on: redirect to 0x102 -> misalign_valid 1 cycle, misalign_pc=0x102, no requests until redirect to 0x200; macro off: same redirect fetches 0x100.
